svm_decision: RTL

Final decision stage of the stage-1 SVM classifier. Consumes the per-support-vector kernel values streamed out of the dot-product slices and weights each by a locally stored coefficient (alpha_i·y_i). Accumulates the weighted sum, adds the bias, and emits the class bit. Sits directly downstream of the dot-product array in the stage-1 datapath and drives the stage's `y_class`.

---
 rtl/svm_pkg.sv | 23 ++
 rtl/svm_coef_rf.sv | 27 ++
 rtl/svm_decision.sv | 126 ++++++++++++
 3 files changed

// File: rtl/svm_pkg.sv
// Shared types and width constants for the stage-1 SVM datapath
// (dot-product slices, decision stage and stage top).
package svm_pkg;

  localparam int XLEN_PIXEL = 8;
  localparam int KW         = 4 * XLEN_PIXEL;
  localparam int COEF_W     = 16;
  localparam int PROD_W     = KW + COEF_W + 1;
  localparam int ACC_W      = 56;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    FINAL
  } svm_state_e;

  // Widen a signed kernel*coefficient product to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return ACC_W'(p);
  endfunction

endpackage

// File: rtl/svm_coef_rf.sv
// Coefficient register file (alpha_i*y_i): asynchronous read, synchronous write.
// Writes are accepted only while the owner allows them.
module svm_coef_rf #(
  parameter int NUM_OF_SV = 100,
  parameter int COEF_W    = 16
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic                         wr_allow_i,
  input  logic [$clog2(NUM_OF_SV)-1:0] waddr_i,
  input  logic [COEF_W-1:0]            wdata_i,
  input  logic [$clog2(NUM_OF_SV)-1:0] raddr_i,
  output logic [COEF_W-1:0]            rdata_o
);

  logic [COEF_W-1:0] mem_q [NUM_OF_SV];

  // NOTE: the array has no reset; coefficients survive rst and are loaded by software.
  always_ff @(posedge clk) begin
    if (we_i && wr_allow_i && (int'(waddr_i) < NUM_OF_SV)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (int'(raddr_i) < NUM_OF_SV) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/svm_decision.sv
// SVM decision stage: weights streamed kernel values by stored coefficients,
// accumulates, adds bias and issues the class bit.
module svm_decision
  import svm_pkg::*;
#(
  parameter int XLEN_PIXEL = 8,
  parameter int NUM_OF_SV  = 100,
  parameter int COEF_W     = 16,
  parameter int ACC_W      = 56
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         k_valid,
  input  logic [4*XLEN_PIXEL-1:0]      k_data,
  output logic                         k_ready,
  input  logic                         coef_we,
  input  logic [$clog2(NUM_OF_SV)-1:0] coef_addr,
  input  logic [COEF_W-1:0]            coef_wdata,
  input  logic [ACC_W-1:0]             bias,
  output logic                         busy,
  output logic                         y_valid,
  output logic                         y_class,
  output logic [ACC_W-1:0]             score
);

  localparam int AW       = $clog2(NUM_OF_SV);
  localparam int K_BITS   = 4 * XLEN_PIXEL;
  localparam int P_BITS   = K_BITS + COEF_W + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_OF_SV - 1);

  svm_state_e                state_q, state_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic signed [P_BITS-1:0]  prod_q, prod_d;
  logic                      prod_v_q, prod_v_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   score_q, score_d, score_next;
  logic                      y_class_q, y_class_d;
  logic                      y_valid_q, y_valid_d;
  logic [COEF_W-1:0]         coef_rd;

  svm_coef_rf #(
    .NUM_OF_SV(NUM_OF_SV),
    .COEF_W   (COEF_W)
  ) u_coef_rf (
    .clk       (clk),
    .we_i      (coef_we),
    .wr_allow_i(state_q == IDLE),
    .waddr_i   (coef_addr),
    .wdata_i   (coef_wdata),
    .raddr_i   (cnt_q),
    .rdata_o   (coef_rd)
  );

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    prod_v_d   = 1'b0;
    acc_d      = prod_v_q ? acc_q + sext_prod(prod_q) : acc_q;
    score_next = acc_q + $signed(bias);
    score_d    = score_q;
    y_class_d  = y_class_q;
    y_valid_d  = 1'b0;
    k_ready    = 1'b0;
    busy       = 1'b1;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (en) begin
          cnt_d   = '0;
          acc_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        k_ready = 1'b1;
        if (k_valid) begin
          // Kernel is unsigned: a zero MSB keeps it positive in the signed multiply.
          prod_d   = P_BITS'($signed({1'b0, k_data})) * P_BITS'($signed(coef_rd));
          prod_v_d = 1'b1;
          cnt_d    = cnt_q + AW'(1);
          if (cnt_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: state_d = FINAL;
      FINAL: begin
        score_d   = score_next;
        y_class_d = ~score_next[ACC_W-1];
        y_valid_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only; all decoding lives above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      prod_v_q  <= 1'b0;
      acc_q     <= '0;
      score_q   <= '0;
      y_class_q <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      prod_v_q  <= prod_v_d;
      acc_q     <= acc_d;
      score_q   <= score_d;
      y_class_q <= y_class_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign score   = score_q;
  assign y_class = y_class_q;
  assign y_valid = y_valid_q;

endmodule
